orao_tap_player: RTL and testbench
==================================

# orao_tap_player

Buffered, rate-controlled cassette playback engine for the ORAO core. It sits between the hps_io ioctl download stream (TAP index) and the CPU-side tape input and audio mixer. Every downloaded byte is one tape sample. The block buffers samples in a FIFO, backpressures the loader through `dl_wait`, and replays one selected bit per sample period at a fixed, parametrised rate instead of at download speed. Pause, underrun and overflow handling are included.

## Interface

Parameters:
- `DEPTH`, 1024: FIFO depth in bytes; must be a power of two, ≥ 8.
- `DIV`, 1134: `clk_sys` cycles per sample (≈ 44.1 kHz at 50 MHz); must be ≥ 2.
- `BIT_SEL`, 6: byte bit that is driven onto the tape line.
- `PRIME`, `DEPTH/2`: FIFO fill level required before playback starts.

Ports:
- `clk_sys` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `dl_active` in 1: TAP download in progress (`ioctl_download` qualified by index).
- `dl_wr` in 1: one-cycle strobe; `dl_data` is valid.
- `dl_data` in 8: sample byte.
- `dl_wait` out 1: backpressure to the loader (`ioctl_wait`).
- `play` in 1: level input; 1 = run, 0 = pause.
- `tape_bit` out 1: registered tape level to the CPU port and audio.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when playback finishes normally.
- `underrun` out 1: sticky flag.
- `overflow` out 1: sticky flag.
- `samples` out 24: samples played since the last restart; saturates at 24'hFFFFFF.

## Operation

- **FIFO**
  - Write on `dl_wr` when not full.
  - A write while full is dropped and sets `overflow`.
  - A pop only occurs on a sample tick in PLAY while not empty.
  - Simultaneous push and pop: count is unchanged, both take effect.
- **Backpressure:** `dl_wait` = (count ≥ DEPTH−2), registered. This leaves two slots for writes already in flight.
- **Restart:** a rising edge of `dl_active` in any state flushes the FIFO, clears `underrun`, `overflow` and `samples`, and enters PRIME. In that same cycle a `dl_wr` is accepted into the now-empty FIFO.
- **States:**
  - IDLE → PRIME on a `dl_active` rise.
  - PRIME → PLAY when count ≥ PRIME, or when `dl_active` falls with count > 0.
  - PRIME → IDLE when `dl_active` falls with count = 0.
  - PLAY → PAUSE when `play`=0. PAUSE → PLAY when `play`=1. The divider holds its value in PAUSE and resumes from there.
  - PLAY → IDLE with a `done` pulse when the FIFO is empty, `dl_active`=0 and a tick occurs.
  - PLAY with the FIFO empty and `dl_active`=1 on a tick: no pop, `tape_bit` holds its value, `underrun` is set, `samples` does not increment.
- **Tick:** the divider resets to 0 on entry to PLAY from PRIME and ticks when it reaches DIV−1.
- **tape_bit:** takes the popped byte's bit `BIT_SEL`. It is forced to 0 on entry to IDLE.

## Timing

- Reset (async assert, sync release): state IDLE, FIFO empty; `tape_bit`, `dl_wait`, `busy`, `done`, `underrun`, `overflow` = 0; `samples` = 0.
- Assertion mid-playback aborts immediately. Nothing resumes after release until the next `dl_active` rise.
- `busy` is set 1 cycle after the `dl_active` rise.
- First tick occurs DIV cycles after PLAY entry. `tape_bit` updates in the cycle after the tick, so latency from tick to output is 1 cycle.
- `dl_wait` lags the count by 1 cycle.
- `done` is high for exactly 1 cycle, coincident with `busy` falling.

## Configuration

- `TAP_PLAYER_STATS_EN`
  - Defined: `underrun`, `overflow` and `samples` are implemented as described.
  - Undefined: those three outputs are tied to 0 and their logic is removed. FIFO and playback behaviour are unchanged; a write while full is still dropped.

## Test plan

All scenarios use DEPTH=16, DIV=4, PRIME=8, BIT_SEL=6.

- **Basic playback:** raise `dl_active`, write 0x40,0x00,0x40,0x00,0x40,0x00,0x40,0x00 back-to-back, `play`=1, drop `dl_active`. Expect PLAY after the 8th write; `tape_bit` sequence 1,0,1,0,1,0,1,0, each held 4 cycles; `done` after the last tick; `samples`=8.
- **Backpressure:** with `play`=0, write 14 bytes. `dl_wait`=1 by the cycle after count=14. Two further writes are accepted (count 16); a 17th write sets `overflow`, count stays 16.
- **Underrun:** after PRIME, `play`=1, `dl_active` held high with no new writes. After 8 ticks `underrun`=1, `tape_bit` holds the last value, `busy` stays 1 and `samples` stays 8.
- **Pause:** deassert `play` with the divider at 2; hold 20 cycles; reassert. The next tick comes 2 cycles later; no sample is lost.
- **Restart:** a second `dl_active` rise during PLAY flushes the FIFO, clears the flags and re-enters PRIME.
- **Reset mid-play:** pulse `reset_n` low mid-play; all outputs read 0 asynchronously within the reset cycle.

Source files
------------

// File: rtl/orao_tap_player.sv
// orao_tap_player: buffered, rate-controlled TAP cassette playback engine for the ORAO core.
//
// Ports:
//   clk_sys    system clock
//   reset_n    asynchronous active-low reset
//   dl_active  TAP download in progress; a rising edge restarts playback
//   dl_wr      one-cycle write strobe for dl_data
//   dl_data    sample byte (one byte = one tape sample)
//   dl_wait    registered backpressure to the loader (count >= DEPTH-2)
//   play       1 = run, 0 = pause
//   tape_bit   registered tape level (bit BIT_SEL of the last played byte)
//   busy       state is not IDLE
//   done       one-cycle pulse when playback ends normally
//   underrun   sticky: a sample tick found the FIFO empty while downloading
//   overflow   sticky: a write arrived while the FIFO was full
//   samples    samples played since the last restart, saturating
//
// Build option: define TAP_PLAYER_STATS_EN to implement underrun, overflow and
// samples; when undefined they are tied to 0.
module orao_tap_player #(
   parameter int DEPTH   = 1024,
   parameter int DIV     = 1134,
   parameter int BIT_SEL = 6,
   parameter int PRIME   = DEPTH / 2
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        dl_active,
   input  logic        dl_wr,
   input  logic [7:0]  dl_data,
   output logic        dl_wait,
   input  logic        play,
   output logic        tape_bit,
   output logic        busy,
   output logic        done,
   output logic        underrun,
   output logic        overflow,
   output logic [23:0] samples
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = $clog2(DIV);

   typedef enum logic [1:0] {S_IDLE, S_PRIME, S_PLAY, S_PAUSE} state_t;

   state_t          state, state_nx;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic [DW-1:0]   div_cnt;
   logic            act_q;
   logic            rise, fall, full, empty, run, tick, push, pop, done_nx;

   assign rise  = dl_active & ~act_q;
   assign fall  = ~dl_active & act_q;
   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;
   assign run   = state == S_PLAY && play;
   assign tick  = run && div_cnt == DW'(DIV - 1);
   // A restart flushes first, so its same-cycle write always fits.
   assign push  = dl_wr && (rise || !full);
   assign pop   = tick && !empty && !rise;
   assign busy  = state != S_IDLE;

   always_comb begin
      state_nx = state;
      done_nx  = 1'b0;
      if (rise)
         state_nx = S_PRIME;
      else
         case (state)
            S_PRIME: begin
               if (count >= CW'(PRIME) || (fall && !empty))
                  state_nx = S_PLAY;
               else if (fall)
                  state_nx = S_IDLE;
            end
            S_PLAY: begin
               if (!play)
                  state_nx = S_PAUSE;
               else if (tick && empty && !dl_active) begin
                  state_nx = S_IDLE;
                  done_nx  = 1'b1;
               end
            end
            S_PAUSE: state_nx = play ? S_PLAY : S_PAUSE;
            default: state_nx = state;
         endcase
   end

   always_ff @(posedge clk_sys)
      if (push)
         mem[rise ? '0 : wr_ptr] <= dl_data;

   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         // act_q resets high so a download still active across reset is not a restart.
         act_q    <= 1'b1;
         state    <= S_IDLE;
         done     <= 1'b0;
         dl_wait  <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         div_cnt  <= '0;
         tape_bit <= 1'b0;
      end else begin
         act_q   <= dl_active;
         state   <= state_nx;
         done    <= done_nx;
         dl_wait <= count >= CW'(DEPTH - 2);
         if (rise) begin
            wr_ptr <= AW'(push);
            rd_ptr <= '0;
            count  <= CW'(push);
         end else begin
            if (push)
               wr_ptr <= wr_ptr + 1'b1;
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
         end
         // Divider only runs while actually playing; PAUSE keeps its phase.
         if (rise || (state != S_PLAY && state != S_PAUSE))
            div_cnt <= '0;
         else if (run)
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (state_nx == S_IDLE && state != S_IDLE)
            tape_bit <= 1'b0;
         else if (pop)
            tape_bit <= mem[rd_ptr][BIT_SEL];
      end

`ifdef TAP_PLAYER_STATS_EN
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         underrun <= 1'b0;
         overflow <= 1'b0;
         samples  <= '0;
      end else if (rise) begin
         underrun <= 1'b0;
         overflow <= 1'b0;
         samples  <= '0;
      end else begin
         if (dl_wr && full)
            overflow <= 1'b1;
         if (tick && empty && dl_active)
            underrun <= 1'b1;
         if (pop && samples != 24'hFFFFFF)
            samples <= samples + 1'b1;
      end
`else
   assign underrun = 1'b0;
   assign overflow = 1'b0;
   assign samples  = 24'd0;
`endif

endmodule

// File: tb/tb_orao_tap_player.sv
// tb_orao_tap_player: directed self-checking bench for orao_tap_player (DEPTH=16, DIV=4, PRIME=8, BIT_SEL=6).
module tb_orao_tap_player;
`ifdef TAP_PLAYER_STATS_EN
   localparam bit ST = 1'b1;
`else
   localparam bit ST = 1'b0;
`endif

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        dl_active = 1'b0;
   logic        dl_wr = 1'b0;
   logic [7:0]  dl_data = 8'h00;
   logic        play = 1'b0;
   logic        dl_wait, tape_bit, busy, done, underrun, overflow;
   logic [23:0] samples;
   int          n_run = 0;
   int          n_fail = 0;

   orao_tap_player #(.DEPTH(16), .DIV(4), .BIT_SEL(6), .PRIME(8)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
      .dl_data(dl_data), .dl_wait(dl_wait), .play(play), .tape_bit(tape_bit),
      .busy(busy), .done(done), .underrun(underrun), .overflow(overflow), .samples(samples)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_tape"}, tape_bit, 0);
      chk({tag, "_wait"}, dl_wait, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_unr"}, underrun, 0);
      chk({tag, "_ovf"}, overflow, 0);
      chk({tag, "_smp"}, samples, 0);
   endtask

   task automatic write8(input logic [7:0] even, input logic [7:0] odd);
      for (int i = 0; i < 8; i++) begin
         dl_wr = 1'b1;
         dl_data = (i % 2 == 0) ? even : odd;
         cyc;
      end
      dl_wr = 1'b0;
   endtask

   initial begin
      int n;
      #2;
      chk_zero("rst");
      cyc;
      cyc;
      reset_n = 1'b1;
      cyc;
      chk_zero("post_rst");

      // Basic playback
      dl_active = 1'b1;
      cyc;
      chk("bas_busy_rise", busy, 1);
      write8(8'h40, 8'h00);
      play = 1'b1;
      dl_active = 1'b0;
      cyc;
      chk("bas_busy_play", busy, 1);
      repeat (3) cyc;
      chk("bas_first_lat", tape_bit, 0);
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 4; j++) begin
            cyc;
            chk($sformatf("bas_tape_%0d_%0d", i, j), tape_bit, (i % 2 == 0) ? 1 : 0);
         end
      chk("bas_done_early", done, 0);
      cyc;
      chk("bas_done", done, 1);
      chk("bas_busy_end", busy, 0);
      chk("bas_samples", samples, ST ? 8 : 0);
      cyc;
      chk("bas_done_1cyc", done, 0);

      // Backpressure and overflow
      play = 1'b0;
      dl_active = 1'b1;
      cyc;
      for (int i = 0; i < 17; i++) begin
         dl_wr = 1'b1;
         dl_data = (i % 2 == 0) ? 8'h40 : 8'h00;
         cyc;
         if (i == 13) chk("bp_wait_lag", dl_wait, 0);
         if (i == 14) chk("bp_wait_set", dl_wait, 1);
         if (i == 15) chk("bp_ovf_clear", overflow, 0);
         if (i == 16) chk("bp_ovf_set", overflow, ST ? 1 : 0);
      end
      dl_wr = 1'b0;
      play = 1'b1;
      dl_active = 1'b0;
      n = 0;
      while (!done && n < 200) begin
         cyc;
         n++;
      end
      chk("bp_done_lat", n, 69);
      chk("bp_busy_end", busy, 0);
      chk("bp_wait_end", dl_wait, 0);
      chk("bp_unr", underrun, 0);

      // Underrun
      dl_active = 1'b1;
      cyc;
      write8(8'h00, 8'h40);
      repeat (4) cyc;
      for (int i = 0; i < 8; i++) begin
         cyc;
         chk($sformatf("unr_tape_%0d", i), tape_bit, (i % 2 == 0) ? 0 : 1);
         repeat (3) cyc;
      end
      chk("unr_before", underrun, 0);
      cyc;
      chk("unr_set", underrun, ST ? 1 : 0);
      chk("unr_tape_hold", tape_bit, 1);
      chk("unr_busy", busy, 1);
      chk("unr_samples", samples, ST ? 8 : 0);
      repeat (4) cyc;
      chk("unr_tape_hold2", tape_bit, 1);
      chk("unr_busy2", busy, 1);
      chk("unr_no_done", done, 0);
      chk("unr_samples2", samples, ST ? 8 : 0);

      // Restart clears flags, then pause
      dl_active = 1'b0;
      cyc;
      dl_active = 1'b1;
      cyc;
      chk("rs1_unr", underrun, 0);
      chk("rs1_samples", samples, 0);
      chk("rs1_busy", busy, 1);
      write8(8'h00, 8'h40);
      repeat (4) cyc;
      chk("pau_pre", tape_bit, 1);
      cyc;
      chk("pau_s0", tape_bit, 0);
      repeat (4) cyc;
      chk("pau_s1", tape_bit, 1);
      repeat (2) cyc;
      play = 1'b0;
      repeat (20) cyc;
      chk("pau_hold", tape_bit, 1);
      chk("pau_busy", busy, 1);
      play = 1'b1;
      repeat (2) cyc;
      chk("pau_resume_wait", tape_bit, 1);
      cyc;
      chk("pau_resume_tick", tape_bit, 0);
      repeat (4) cyc;
      chk("pau_s3", tape_bit, 1);
      chk("pau_samples", samples, ST ? 4 : 0);

      // Restart mid-play with data left in the FIFO
      dl_active = 1'b0;
      cyc;
      dl_active = 1'b1;
      cyc;
      chk("rs2_busy", busy, 1);
      chk("rs2_samples", samples, 0);
      repeat (12) cyc;
      chk("rs2_flushed", tape_bit, 1);
      dl_active = 1'b0;
      cyc;
      chk("rs2_idle", busy, 0);
      chk("rs2_tape_zero", tape_bit, 0);
      chk("rs2_no_done", done, 0);

      // Reset mid-play
      dl_active = 1'b1;
      cyc;
      write8(8'h40, 8'h40);
      repeat (5) cyc;
      chk("rmp_tape", tape_bit, 1);
      chk("rmp_busy", busy, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_zero("rmp_async");
      repeat (2) cyc;
      reset_n = 1'b1;
      repeat (4) cyc;
      chk("rmp_no_resume", busy, 0);
      chk("rmp_tape_after", tape_bit, 0);
      dl_active = 1'b0;
      cyc;

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
